// File: rtl/reg_bus_reader_pkg.sv
// Shared codes for the register-bus reader: command codes, per-register
// read-lane selects, per-register op codes and the controller state encoding.
package reg_bus_reader_pkg;

    // Commands accepted on i_cmd; code 3 is unassigned and always rejected.
    localparam logic [1:0] BRD_CMD_MOV       = 2'd0;
    localparam logic [1:0] BRD_CMD_READ8     = 2'd1;
    localparam logic [1:0] BRD_CMD_LOAD_ADDR = 2'd2;

    // Per-register read code: which bus lane (if any) the register drives.
    localparam logic [1:0] REG_READ_NONE = 2'd0;
    localparam logic [1:0] REG_READ_TO_0 = 2'd1;
    localparam logic [1:0] REG_READ_TO_1 = 2'd2;
    localparam logic [1:0] REG_READ_TO_2 = 2'd3;

    // Per-register op code; this block only ever issues NOP and WRITE.
    localparam logic [2:0] REG_OP_NOP   = 3'd0;
    localparam logic [2:0] REG_OP_WRITE = 3'd1;

    typedef enum logic [2:0] {
        BRD_ST_IDLE   = 3'd0,
        BRD_ST_DRIVE  = 3'd1,
        BRD_ST_DRIVE2 = 3'd2,
        BRD_ST_SAMPLE = 3'd3,
        BRD_ST_DONE   = 3'd4,
        BRD_ST_ERR    = 3'd5
    } brd_state_t;

    // Selects are held on the bus from the first settle cycle through sampling.
    function automatic logic is_driving(input brd_state_t st);
        return (st == BRD_ST_DRIVE) || (st == BRD_ST_DRIVE2) || (st == BRD_ST_SAMPLE);
    endfunction

endpackage

// File: rtl/reg_bus_reader_decode.sv
// Combinational map from (state, command, indices) to the per-register
// read-select and op-code vectors. The parent feeds it the next state and
// next command fields and registers the result.
module reg_bus_reader_decode
    import reg_bus_reader_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  brd_state_t                state,
    input  logic [1:0]                cmd,
    input  logic [IDX_W-1:0]          src0,
    input  logic [IDX_W-1:0]          src1,
    input  logic [IDX_W-1:0]          src2,
    input  logic [IDX_W-1:0]          dst,
    output logic [2*NUM_REGS-1:0]     read_sel,
    output logic [3*NUM_REGS-1:0]     reg_op
);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [IDX_W-1:0] K = IDX_W'(gi);
            logic [1:0] sel_k;
            logic [2:0] op_k;

            // Lane choice for register gi; only one lane per register and,
            // because accepted LOAD_ADDR indices are distinct, one register per lane.
            always_comb begin
                sel_k = REG_READ_NONE;
                if (is_driving(state)) begin
                    if (src0 == K) begin
                        sel_k = REG_READ_TO_0;
                    end else if (cmd == BRD_CMD_LOAD_ADDR && src1 == K) begin
                        sel_k = REG_READ_TO_1;
                    end else if (cmd == BRD_CMD_LOAD_ADDR && src2 == K) begin
                        sel_k = REG_READ_TO_2;
                    end
                end
            end

            // Destination write strobe, present only while lane 0 is being sampled.
            always_comb begin
                op_k = REG_OP_NOP;
                if (state == BRD_ST_SAMPLE && cmd == BRD_CMD_MOV && dst == K) begin
                    op_k = REG_OP_WRITE;
                end
            end

            assign read_sel[2*gi +: 2] = sel_k;
            assign reg_op[3*gi +: 3]   = op_k;
        end
    endgenerate

endmodule

// File: rtl/reg_bus_reader.sv
// Register-bus reader: sequences read selects onto the three-lane io_bus,
// samples it, and returns a 24-bit address, an 8-bit byte, or performs a
// lane-0 register-to-register move.
// Optional macro BUS_READER_SETTLE_EN adds a second bus-settle cycle (DRIVE2).
module reg_bus_reader
    import reg_bus_reader_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [1:0]                i_cmd,
    input  logic [IDX_W-1:0]          i_src0,
    input  logic [IDX_W-1:0]          i_src1,
    input  logic [IDX_W-1:0]          i_src2,
    input  logic [IDX_W-1:0]          i_dst,
    input  logic [23:0]               i_bus,
    output logic [2*NUM_REGS-1:0]     o_read_sel,
    output logic [3*NUM_REGS-1:0]     o_reg_op,
    output logic                      o_ready,
    output logic                      o_done,
    output logic                      o_err,
    output logic [23:0]               o_addr,
    output logic [7:0]                o_data
);

    // NUM_REGS always fits in IDX_W+1 bits since 2**IDX_W >= NUM_REGS.
    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

    brd_state_t             state_reg, state_next;
    logic [1:0]             cmd_reg, cmd_next;
    logic [IDX_W-1:0]       src0_reg, src0_next;
    logic [IDX_W-1:0]       src1_reg, src1_next;
    logic [IDX_W-1:0]       src2_reg, src2_next;
    logic [IDX_W-1:0]       dst_reg, dst_next;
    logic [2*NUM_REGS-1:0]  read_sel_reg, read_sel_next;
    logic [3*NUM_REGS-1:0]  reg_op_reg, reg_op_next;
    logic                   ready_reg, done_reg, err_reg;
    logic [23:0]            addr_reg;
    logic [7:0]             data_reg;
    logic                   reject;

    // Reject on out-of-range indices, unknown command, or a LOAD_ADDR that
    // would put two registers on the bus at once.
    always_comb begin
        reject = 1'b0;
        case (i_cmd)
            BRD_CMD_MOV:
                reject = ({1'b0, i_src0} >= NUM_REGS_W) || ({1'b0, i_dst} >= NUM_REGS_W);
            BRD_CMD_READ8:
                reject = ({1'b0, i_src0} >= NUM_REGS_W);
            BRD_CMD_LOAD_ADDR:
                reject = ({1'b0, i_src0} >= NUM_REGS_W) || ({1'b0, i_src1} >= NUM_REGS_W) ||
                         ({1'b0, i_src2} >= NUM_REGS_W) || (i_src0 == i_src1) ||
                         (i_src0 == i_src2) || (i_src1 == i_src2);
            default:
                reject = 1'b1;
        endcase
    end

    // Next-state logic; command fields are captured only when a start is taken in IDLE.
    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        src0_next  = src0_reg;
        src1_next  = src1_reg;
        src2_next  = src2_reg;
        dst_next   = dst_reg;
        case (state_reg)
            BRD_ST_IDLE: begin
                if (i_start) begin
                    cmd_next   = i_cmd;
                    src0_next  = i_src0;
                    src1_next  = i_src1;
                    src2_next  = i_src2;
                    dst_next   = i_dst;
                    state_next = reject ? BRD_ST_ERR : BRD_ST_DRIVE;
                end
            end
`ifdef BUS_READER_SETTLE_EN
            BRD_ST_DRIVE:  state_next = BRD_ST_DRIVE2;
`else
            BRD_ST_DRIVE:  state_next = BRD_ST_SAMPLE;
`endif
            BRD_ST_DRIVE2: state_next = BRD_ST_SAMPLE;
            BRD_ST_SAMPLE: state_next = BRD_ST_DONE;
            BRD_ST_DONE:   state_next = BRD_ST_IDLE;
            BRD_ST_ERR:    state_next = BRD_ST_IDLE;
            default:       state_next = BRD_ST_IDLE;
        endcase
    end

    // Decoding the next state lets the registered selects line up with the state they belong to.
    reg_bus_reader_decode #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_decode (
        .state    (state_next),
        .cmd      (cmd_next),
        .src0     (src0_next),
        .src1     (src1_next),
        .src2     (src2_next),
        .dst      (dst_next),
        .read_sel (read_sel_next),
        .reg_op   (reg_op_next)
    );

    // State, output registers and end-of-SAMPLE capture of the bus.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= BRD_ST_IDLE;
            cmd_reg      <= BRD_CMD_MOV;
            src0_reg     <= '0;
            src1_reg     <= '0;
            src2_reg     <= '0;
            dst_reg      <= '0;
            read_sel_reg <= {NUM_REGS{REG_READ_NONE}};
            reg_op_reg   <= {NUM_REGS{REG_OP_NOP}};
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            src0_reg     <= src0_next;
            src1_reg     <= src1_next;
            src2_reg     <= src2_next;
            dst_reg      <= dst_next;
            read_sel_reg <= read_sel_next;
            reg_op_reg   <= reg_op_next;
            ready_reg    <= (state_next == BRD_ST_IDLE);
            done_reg     <= (state_next == BRD_ST_DONE);
            err_reg      <= (state_next == BRD_ST_ERR);
            if (state_reg == BRD_ST_SAMPLE) begin
                if (cmd_reg == BRD_CMD_READ8) begin
                    data_reg <= i_bus[7:0];
                end
                if (cmd_reg == BRD_CMD_LOAD_ADDR) begin
                    addr_reg <= i_bus;
                end
            end
        end
    end

    assign o_read_sel = read_sel_reg;
    assign o_reg_op   = reg_op_reg;
    assign o_ready    = ready_reg;
    assign o_done     = done_reg;
    assign o_err      = err_reg;
    assign o_addr     = addr_reg;
    assign o_data     = data_reg;

endmodule

// File: tb/tb_reg_bus_reader.sv
// Bench for reg_bus_reader: a small register file and bus model surround the
// DUT; expectations come from the command rules and cycle timing.
module tb_reg_bus_reader;
    import reg_bus_reader_pkg::*;

    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 4;
`ifdef BUS_READER_SETTLE_EN
    localparam int DRV_CYC = 2;
`else
    localparam int DRV_CYC = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  start;
    logic [1:0]            cmd;
    logic [IDX_W-1:0]      src0, src1, src2, dst;
    logic [23:0]           bus;
    logic [2*NUM_REGS-1:0] read_sel;
    logic [3*NUM_REGS-1:0] reg_op;
    logic                  ready, done, err;
    logic [23:0]           addr;
    logic [7:0]            data;

    reg_bus_reader #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_cmd(cmd),
        .i_src0(src0), .i_src1(src1), .i_src2(src2), .i_dst(dst),
        .i_bus(bus), .o_read_sel(read_sel), .o_reg_op(reg_op),
        .o_ready(ready), .o_done(done), .o_err(err), .o_addr(addr), .o_data(data)
    );

    // Register file model
    logic [7:0] regs [NUM_REGS];
    logic       load_en = 1'b0;
    int         load_idx = 0;
    logic [7:0] load_val = 8'h00;

    always @(posedge clk) begin
        if (load_en) begin
            regs[load_idx] <= load_val;
        end else begin
            for (int k = 0; k < NUM_REGS; k++)
                if (reg_op[3*k +: 3] == REG_OP_WRITE) regs[k] <= bus[7:0];
        end
    end

    always_comb begin
        logic [23:0] acc;
        acc = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            case (read_sel[2*k +: 2])
                REG_READ_TO_0: acc[7:0]   = acc[7:0]   | regs[k];
                REG_READ_TO_1: acc[15:8]  = acc[15:8]  | regs[k];
                REG_READ_TO_2: acc[23:16] = acc[23:16] | regs[k];
                default: ;
            endcase
        end
        bus = acc;
    end

    int contention = 0;
    always @(negedge clk) begin
        automatic int n0 = 0;
        automatic int n1 = 0;
        automatic int n2 = 0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (read_sel[2*k +: 2] == REG_READ_TO_0) n0++;
            if (read_sel[2*k +: 2] == REG_READ_TO_1) n1++;
            if (read_sel[2*k +: 2] == REG_READ_TO_2) n2++;
        end
        if (n0 > 1 || n1 > 1 || n2 > 1) contention++;
    end

    int checks = 0;
    int errors = 0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_data = '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input int k, input logic [7:0] v);
        load_en = 1'b1; load_idx = k; load_val = v;
        tick;
        load_en = 1'b0;
    endtask

    function automatic bit model_legal(input logic [1:0] c, input int a0, input int a1,
                                       input int a2, input int ad);
        case (c)
            BRD_CMD_MOV:       return (a0 < NUM_REGS) && (ad < NUM_REGS);
            BRD_CMD_READ8:     return (a0 < NUM_REGS);
            BRD_CMD_LOAD_ADDR: return (a0 < NUM_REGS) && (a1 < NUM_REGS) && (a2 < NUM_REGS) &&
                                      (a0 != a1) && (a0 != a2) && (a1 != a2);
            default:           return 1'b0;
        endcase
    endfunction

    // Issue one command and check every cycle until o_ready returns.
    task automatic run_cmd(input logic [1:0] c, input int a0, input int a1, input int a2,
                           input int ad, input bit poke, input bit b2b);
        logic [7:0]            snap [NUM_REGS];
        logic [2*NUM_REGS-1:0] dsel;
        logic [3*NUM_REGS-1:0] wop;
        logic [2*NUM_REGS-1:0] e_sel;
        logic [3*NUM_REGS-1:0] e_op;
        logic [23:0]           new_addr, e_addr;
        logic [7:0]            new_data, e_data;
        bit                    legal;
        int                    tlast;
        int                    bad_regs;
        snap  = regs;
        legal = model_legal(c, a0, a1, a2, ad);
        dsel = '0; wop = '0;
        new_addr = m_addr; new_data = m_data;
        if (legal) begin
            dsel[2*a0 +: 2] = REG_READ_TO_0;
            if (c == BRD_CMD_LOAD_ADDR) begin
                dsel[2*a1 +: 2] = REG_READ_TO_1;
                dsel[2*a2 +: 2] = REG_READ_TO_2;
                new_addr = {snap[a2], snap[a1], snap[a0]};
            end
            if (c == BRD_CMD_READ8) new_data = snap[a0];
            if (c == BRD_CMD_MOV)   wop[3*ad +: 3] = REG_OP_WRITE;
        end
        tlast = legal ? DRV_CYC + 3 : 2;
        if (!b2b) tick;
        start = 1'b1; cmd = c;
        src0 = IDX_W'(a0); src1 = IDX_W'(a1); src2 = IDX_W'(a2); dst = IDX_W'(ad);
        tick;
        for (int t = 1; t <= tlast; t++) begin
            start = poke && (t < tlast);
            if (poke) begin
                cmd  = 2'($urandom_range(0, 2));
                src0 = IDX_W'($urandom_range(0, NUM_REGS - 1));
                dst  = IDX_W'($urandom_range(0, NUM_REGS - 1));
            end
            e_sel  = (legal && t <= DRV_CYC + 1) ? dsel : '0;
            e_op   = (legal && t == DRV_CYC + 1) ? wop : '0;
            e_addr = (legal && t >= DRV_CYC + 2) ? new_addr : m_addr;
            e_data = (legal && t >= DRV_CYC + 2) ? new_data : m_data;
            checks += 7;
            if (read_sel !== e_sel) begin
                errors++; $display("FAIL read_sel t=%0d got %h want %h", t, read_sel, e_sel);
            end
            if (reg_op !== e_op) begin
                errors++; $display("FAIL reg_op t=%0d got %h want %h", t, reg_op, e_op);
            end
            if (ready !== (t == tlast)) begin
                errors++; $display("FAIL ready t=%0d got %b want %b", t, ready, (t == tlast));
            end
            if (done !== (legal && t == DRV_CYC + 2)) begin
                errors++; $display("FAIL done t=%0d got %b want %b", t, done, (legal && t == DRV_CYC + 2));
            end
            if (err !== (!legal && t == 1)) begin
                errors++; $display("FAIL err t=%0d got %b want %b", t, err, (!legal && t == 1));
            end
            if (addr !== e_addr) begin
                errors++; $display("FAIL addr t=%0d got %h want %h", t, addr, e_addr);
            end
            if (data !== e_data) begin
                errors++; $display("FAIL data t=%0d got %h want %h", t, data, e_data);
            end
            if (t < tlast) tick;
        end
        start = 1'b0;
        m_addr = new_addr;
        m_data = new_data;
        bad_regs = 0;
        for (int k = 0; k < NUM_REGS; k++) begin
            logic [7:0] e_r;
            e_r = (legal && c == BRD_CMD_MOV && k == ad) ? snap[a0] : snap[k];
            if (regs[k] !== e_r) begin
                bad_regs++;
                $display("FAIL regfile r%0d got %h want %h", k, regs[k], e_r);
            end
        end
        checks++;
        if (bad_regs != 0) errors++;
        $display("txn cmd=%0d src=%0d/%0d/%0d dst=%0d legal=%0d addr=%h data=%h",
                 c, a0, a1, a2, ad, legal, addr, data);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cmd = '0;
        src0 = '0; src1 = '0; src2 = '0; dst = '0;
        tick; tick;
        checks += 3;
        if (read_sel !== '0 || reg_op !== '0) begin
            errors++; $display("FAIL reset_sel_op got %h/%h want 0/0", read_sel, reg_op);
        end
        if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got r%b d%b e%b want r1 d0 e0", ready, done, err);
        end
        if (addr !== 24'h0 || data !== 8'h0) begin
            errors++; $display("FAIL reset_data got %h/%h want 0/0", addr, data);
        end
        rst = 1'b0;
        m_addr = '0; m_data = '0;
        for (int k = 0; k < NUM_REGS; k++) load_reg(k, 8'(k * 16 + 1));
        $display("txn reset");
    endtask

    task automatic test_read8;
        load_reg(3, 8'h5A);
        run_cmd(BRD_CMD_READ8, 3, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_load_addr;
        load_reg(1, 8'h11); load_reg(2, 8'h22); load_reg(4, 8'h33);
        run_cmd(BRD_CMD_LOAD_ADDR, 1, 2, 4, 0, 1'b0, 1'b0);
        checks++;
        if (m_addr !== 24'h332211) begin
            errors++; $display("FAIL load_addr_value got %h want 332211", addr);
        end
    endtask

    task automatic test_mov;
        load_reg(0, 8'hC3); load_reg(5, 8'h00);
        run_cmd(BRD_CMD_MOV, 0, 0, 0, 5, 1'b0, 1'b0);
        checks++;
        if (regs[5] !== 8'hC3 || regs[0] !== 8'hC3) begin
            errors++; $display("FAIL mov_regs got r0=%h r5=%h want C3/C3", regs[0], regs[5]);
        end
        run_cmd(BRD_CMD_MOV, 6, 0, 0, 6, 1'b0, 1'b0);
    endtask

    task automatic test_reject;
        run_cmd(BRD_CMD_LOAD_ADDR, 2, 2, 6, 0, 1'b0, 1'b0);
        run_cmd(BRD_CMD_LOAD_ADDR, 1, 9, 3, 0, 1'b0, 1'b0);
        run_cmd(BRD_CMD_READ8, 9, 0, 0, 0, 1'b0, 1'b0);
        run_cmd(BRD_CMD_MOV, 1, 0, 0, 8, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignored;
        run_cmd(BRD_CMD_READ8, 4, 0, 0, 0, 1'b1, 1'b0);
        run_cmd(BRD_CMD_LOAD_ADDR, 7, 0, 5, 0, 1'b1, 1'b0);
        run_cmd(BRD_CMD_LOAD_ADDR, 3, 3, 5, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_cmd(BRD_CMD_READ8, 2, 0, 0, 0, 1'b0, 1'b0);
        run_cmd(BRD_CMD_LOAD_ADDR, 0, 6, 7, 0, 1'b0, 1'b1);
        run_cmd(BRD_CMD_MOV, 7, 0, 0, 1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic [2*NUM_REGS-1:0] e_sel;
        load_reg(0, 8'hC3); load_reg(5, 8'h00);
        tick;
        start = 1'b1; cmd = BRD_CMD_MOV; src0 = 4'd0; dst = 4'd5;
        tick;
        start = 1'b0;
        e_sel = '0; e_sel[1:0] = REG_READ_TO_0;
        checks++;
        if (read_sel !== e_sel) begin
            errors++; $display("FAIL mid_drive_sel got %h want %h", read_sel, e_sel);
        end
        for (int t = 2; t <= DRV_CYC; t++) tick;
        rst = 1'b1;
        tick;
        checks += 2;
        if (read_sel !== '0 || reg_op !== '0) begin
            errors++; $display("FAIL mid_reset_sel_op got %h/%h want 0/0", read_sel, reg_op);
        end
        if (ready !== 1'b1 || done !== 1'b0 || addr !== 24'h0 || data !== 8'h0) begin
            errors++; $display("FAIL mid_reset_state got r%b d%b %h %h want r1 d0 0 0",
                               ready, done, addr, data);
        end
        rst = 1'b0;
        m_addr = '0; m_data = '0;
        tick; tick;
        checks++;
        if (regs[5] !== 8'h00 || regs[0] !== 8'hC3) begin
            errors++; $display("FAIL mid_reset_regs got r0=%h r5=%h want C3/00", regs[0], regs[5]);
        end
        $display("txn reset_mid mov 0->5");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NUM_REGS; k++) load_reg(k, 8'($urandom));
            run_cmd(2'($urandom_range(0, 2)),
                    $urandom_range(0, NUM_REGS + 1), $urandom_range(0, NUM_REGS + 1),
                    $urandom_range(0, NUM_REGS + 1), $urandom_range(0, NUM_REGS + 1),
                    1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_contention;
        checks++;
        if (contention != 0) begin
            errors++; $display("FAIL lane_contention got %0d want 0", contention);
        end
    endtask

    initial begin
        test_reset;
        test_read8;
        test_load_addr;
        test_mov;
        test_reject;
        test_busy_ignored;
        test_back_to_back;
        test_reset_mid;
        test_random;
        test_contention;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
